// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC EMA filter stage.
package adc_pkg;

  localparam int unsigned ADC_NUM_CH = 9;
  localparam int unsigned ADC_DATA_W = 12;
  localparam int unsigned ADC_CH_W   = $clog2(ADC_NUM_CH);

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    DONE
  } filt_state_e;

endpackage

// File: rtl/adc_ema_deadband.sv
// Combinational EMA update with hysteresis deadband for one channel.
module adc_ema_deadband
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W   = ADC_DATA_W,
  parameter int unsigned SHIFT    = 3,
  parameter int unsigned DEADBAND = 8
) (
  input  logic [DATA_W+SHIFT-1:0] acc_i,
  input  logic [DATA_W-1:0]       x_i,
  input  logic [DATA_W-1:0]       prev_i,
  input  logic                    primed_i,
  output logic [DATA_W+SHIFT-1:0] acc_next_o,
  output logic [DATA_W-1:0]       filt_o,
  output logic                    changed_o
);

  localparam int unsigned ACC_W = DATA_W + SHIFT;

  logic [ACC_W:0]         sum;
  logic [DATA_W-1:0]      ema_filt;
  logic signed [DATA_W:0] diff;
  logic [DATA_W:0]        mag;
  logic                   over_band;
  logic                   unused_sum_msb;

  always_comb begin
    // acc - acc/2^SHIFT + x never exceeds ACC_W bits; the extra bit only absorbs the subtraction.
    sum       = {1'b0, acc_i} - ({1'b0, acc_i} >> SHIFT) + {{(SHIFT + 1){1'b0}}, x_i};
    ema_filt  = sum[SHIFT +: DATA_W];
    diff      = $signed({1'b0, ema_filt}) - $signed({1'b0, prev_i});
    mag       = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    over_band = (diff != '0) && (mag >= (DATA_W + 1)'(DEADBAND));

    if (primed_i) begin
      acc_next_o = sum[ACC_W-1:0];
      filt_o     = over_band ? ema_filt : prev_i;
      changed_o  = over_band;
    end else begin
      acc_next_o = ACC_W'(x_i) << SHIFT;
      filt_o     = x_i;
      changed_o  = 1'b1;
    end
  end

  assign unused_sum_msb = sum[ACC_W];

endmodule

// File: rtl/adc_ema_filter.sv
// Snapshots all ADC channels on AdcRefresh and runs a shared EMA/deadband datapath over them.
module adc_ema_filter
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH   = ADC_NUM_CH,
  parameter int unsigned DATA_W   = ADC_DATA_W,
  parameter int unsigned SHIFT    = 3,
  parameter int unsigned DEADBAND = 8
) (
  input  logic                       Clock_qsys,
  input  logic                       Reset,
  input  logic [NUM_CH*DATA_W-1:0]   AdcValueBus,
  input  logic                       AdcRefresh,
  output logic [NUM_CH*DATA_W-1:0]   FiltValueBus,
  output logic [NUM_CH-1:0]          ChangedMask,
  output logic                       FiltRefresh,
  output logic                       Busy,
  output logic                       Overrun
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ACC_W = DATA_W + SHIFT;

  filt_state_e       state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              primed_q, primed_d;
  logic [DATA_W-1:0] snap_q [NUM_CH];
  logic [DATA_W-1:0] snap_d [NUM_CH];
  logic [ACC_W-1:0]  acc_q  [NUM_CH];
  logic [ACC_W-1:0]  acc_d  [NUM_CH];
  logic [DATA_W-1:0] filt_q [NUM_CH];
  logic [DATA_W-1:0] filt_d [NUM_CH];
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              filt_refresh_q, filt_refresh_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic [ACC_W-1:0]  dp_acc_next;
  logic [DATA_W-1:0] dp_filt;
  logic              dp_changed;

  adc_ema_deadband #(
    .DATA_W  (DATA_W),
    .SHIFT   (SHIFT),
    .DEADBAND(DEADBAND)
  ) u_datapath (
    .acc_i     (acc_q[ch_q]),
    .x_i       (snap_q[ch_q]),
    .prev_i    (filt_q[ch_q]),
    .primed_i  (primed_q),
    .acc_next_o(dp_acc_next),
    .filt_o    (dp_filt),
    .changed_o (dp_changed)
  );

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    primed_d       = primed_q;
    snap_d         = snap_q;
    acc_d          = acc_q;
    filt_d         = filt_q;
    mask_d         = mask_q;
    filt_refresh_d = 1'b0;
    overrun_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (AdcRefresh) begin
          for (int i = 0; i < NUM_CH; i++) begin
            snap_d[i] = AdcValueBus[i*DATA_W +: DATA_W];
          end
          mask_d  = '0;
          ch_d    = '0;
          state_d = PROC;
        end
      end
      PROC: begin
        overrun_d   = AdcRefresh;
        acc_d[ch_q] = dp_acc_next;
        if (dp_changed) begin
          filt_d[ch_q] = dp_filt;
          mask_d[ch_q] = 1'b1;
        end
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          state_d = DONE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      DONE: begin
        overrun_d      = AdcRefresh;
        filt_refresh_d = 1'b1;
        primed_d       = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock_qsys or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      ch_q           <= '0;
      primed_q       <= 1'b0;
      snap_q         <= '{default: '0};
      acc_q          <= '{default: '0};
      filt_q         <= '{default: '0};
      mask_q         <= '0;
      filt_refresh_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      primed_q       <= primed_d;
      snap_q         <= snap_d;
      acc_q          <= acc_d;
      filt_q         <= filt_d;
      mask_q         <= mask_d;
      filt_refresh_q <= filt_refresh_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  always_comb begin
    FiltValueBus = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      FiltValueBus[i*DATA_W +: DATA_W] = filt_q[i];
    end
  end

  assign ChangedMask = mask_q;
  assign FiltRefresh = filt_refresh_q;
  assign Busy        = busy_q;
  assign Overrun     = overrun_q;

endmodule
